// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, clock deglitch filter, frame
// deserialiser with start/parity/stop/timeout checks, and a show-ahead FIFO.
module ps2_rx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 1,
    parameter int unsigned FILT_LEN   = 4,
    parameter int unsigned TIMEOUT    = 3400,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     ck,
    input  logic                     reset,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic [DATA_BITS-1:0]     data_out,
    output logic                     data_valid,
    input  logic                     data_ack,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     timeout_err,
    output logic                     overrun,
    output logic                     busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned BW = $clog2(DATA_BITS) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned FW = $clog2(FILT_LEN);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic               clk_s1, clk_s2, dat_s1, dat_s2;
    logic               filt_q;
    logic [FW-1:0]      fcnt_q;
    logic               fall_c;

    state_t             state_q, state_d;
    logic [BW-1:0]      bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic               par_q, par_d;
    logic [TW-1:0]      tcnt_q;
    logic               tout_hit_c, par_ok_c;
    logic               push_c, perr_d, ferr_d, tout_d;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic               pop_c, full_c, do_push_c;
    logic [CW-1:0]      count_d;
    logic [DATA_BITS-1:0] head_d;

    // Two-flop synchronisers; idle-high so reset produces no edge.
    always_ff @(posedge ck) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock follows the synced line only after FILT_LEN differing samples.
    always_ff @(posedge ck) begin
        if (reset) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else if (clk_s2 != filt_q) begin
            if (fcnt_q == FW'(FILT_LEN - 1)) begin
                filt_q <= clk_s2;
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + FW'(1);
            end
        end else begin
            fcnt_q <= '0;
        end
    end

    // Fall strobe: the cycle in which the filtered clock is switching 1->0.
    assign fall_c = filt_q & ~clk_s2 & (fcnt_q == FW'(FILT_LEN - 1));

    // Inter-edge timer, held at zero while idle and restarted by each fall.
    always_ff @(posedge ck) begin
        if (reset || fall_c || state_q == IDLE) begin
            tcnt_q <= '0;
        end else if (tcnt_q != TW'(TIMEOUT)) begin
            tcnt_q <= tcnt_q + TW'(1);
        end
    end

    assign tout_hit_c = (state_q != IDLE) && (tcnt_q == TW'(TIMEOUT));
    assign par_ok_c   = (PARITY_EN == 0) || ((^shreg_q ^ par_q) == (PARITY_ODD != 0));

    // Frame FSM state register.
    always_ff @(posedge ck) begin
        if (reset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
        end
    end

    // Frame FSM next-state and per-frame verdict.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        push_c   = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        tout_d   = 1'b0;
        if (tout_hit_c) begin
            state_d = IDLE;
            tout_d  = 1'b1;
        end else if (fall_c) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat_s2) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end
                DATA: begin
                    shreg_d  = DATA_BITS'({dat_s2, shreg_q} >> 1);
                    bitcnt_d = bitcnt_q + BW'(1);
                    if (bitcnt_q == BW'(DATA_BITS - 1)) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    par_d   = dat_s2;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!dat_s2) begin
                        ferr_d = 1'b1;
                    end else if (!par_ok_c) begin
                        perr_d = 1'b1;
                    end else begin
                        push_c = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign pop_c     = data_valid & data_ack;
    assign full_c    = (fifo_count == CW'(DEPTH));
    assign do_push_c = push_c & (~full_c | pop_c);
    assign count_d   = fifo_count + CW'(do_push_c) - CW'(pop_c);

    // Next show-ahead head word.
    always_comb begin
        head_d = data_out;
        if (pop_c) begin
            if (fifo_count > CW'(1)) begin
                head_d = mem[rd_ptr_q + PW'(1)];
            end else if (do_push_c) begin
                head_d = shreg_q;
            end else begin
                head_d = '0;
            end
        end else if (fifo_count == '0 && do_push_c) begin
            head_d = shreg_q;
        end
    end

    // FIFO storage; entries are not reset, only pointers and count.
    always_ff @(posedge ck) begin
        if (do_push_c) begin
            mem[wr_ptr_q] <= shreg_q;
        end
    end

    // FIFO pointers, registered head, flags and status pulses.
    always_ff @(posedge ck) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_count  <= '0;
            data_valid  <= 1'b0;
            data_out    <= '0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (do_push_c) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            fifo_count  <= count_d;
            data_valid  <= (count_d != '0);
            data_out    <= head_d;
            parity_err  <= perr_d;
            frame_err   <= ferr_d;
            timeout_err <= tout_d;
            overrun     <= push_c & full_c & ~pop_c;
            busy        <= (state_d != IDLE);
        end
    end

endmodule
